// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: row-buffer data in, raster and DAC signals out.
// test_en exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int COLOR_BITS = 2
);
  logic [15:0]           pixel_data;
  logic [9:0]            h_counter;
  logic [9:0]            v_counter;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;
  logic                  start_row;
  logic                  start_frame;
`ifdef VGA_TEST_PATTERN_EN
  logic                  test_en;

  modport master (
    input  pixel_data, test_en,
    output h_counter, v_counter, hsync, vsync, de, red, green, blue, start_row, start_frame
  );
  modport slave (
    output pixel_data, test_en,
    input  h_counter, v_counter, hsync, vsync, de, red, green, blue, start_row, start_frame
  );
`else
  modport master (
    input  pixel_data,
    output h_counter, v_counter, hsync, vsync, de, red, green, blue, start_row, start_frame
  );
  modport slave (
    output pixel_data,
    input  h_counter, v_counter, hsync, vsync, de, red, green, blue, start_row, start_frame
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: H/V counters, sync, de, reduced RGB and row/frame prefetch pulses.
// Optional vertical-bar test pattern is compiled in with VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int COLOR_BITS    = 2,
  parameter int PIXEL_LATENCY = 0,
  parameter int ROW_REQ_H     = 640,
  parameter int BYTE_SWAP     = 1
) (
  input logic                clk_25M,
  input logic                rst_n,
  vga_timing_gen_if.master   vga
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_SS      = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE      = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS      = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE      = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] ROW_REQ   = 10'(ROW_REQ_H);
  localparam logic       HS_IDLE   = (HSYNC_POL == 0) ? 1'b1 : 1'b0;
  localparam logic       VS_IDLE   = (VSYNC_POL == 0) ? 1'b1 : 1'b0;
  // Pipe word: [0] hsync active, [1] vsync active, [2] de, [5:3] test bar index
`ifdef VGA_TEST_PATTERN_EN
  localparam int         PW        = 6;
  localparam logic [9:0] BAR_W     = 10'(H_ACTIVE / 8);
`else
  localparam int         PW        = 3;
`endif

  logic [9:0]            h_q, h_d, v_q, v_d;
  logic                  start_row_q, start_row_d, start_frame_q, start_frame_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [PW-1:0]         stage0_s, tap_s;
  logic                  row_req_s;
  logic [4:0]            r5_s, b5_s;
  logic [5:0]            g6_s;

  // Round an n-bit component to COLOR_BITS: bump only when the dropped part exceeds half, saturating.
  function automatic logic [COLOR_BITS-1:0] reduce_c(input logic [5:0] c, input int n);
    logic [COLOR_BITS-1:0] top;
    logic [6:0]            rem2;
    logic [6:0]            full;
    top  = c[n-1 -: COLOR_BITS];
    rem2 = {1'b0, c & ((6'd1 << (n - COLOR_BITS)) - 6'd1)} << 1;
    full = 7'd1 << (n - COLOR_BITS);
    if (&top) begin
      reduce_c = top;
    end else if (rem2 > full) begin
      reduce_c = top + COLOR_BITS'(1'b1);
    end else begin
      reduce_c = top;
    end
  endfunction

  // Raster counters: h wraps every line, v advances on the h wrap.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      if (v_q == V_LAST) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  // Prefetch pulses: skip the last active row, since its successor is blanking.
  always_comb begin
    row_req_s     = (h_q == ROW_REQ) && ((v_q == V_LAST) || (v_q < V_ACT_M1));
    start_row_d   = row_req_s;
    start_frame_d = row_req_s && (v_q == V_LAST);
  end

  // Stage-0 timing word derived from the current counters.
  always_comb begin
    stage0_s    = {PW{1'b0}};
    stage0_s[0] = (h_q >= H_SS) && (h_q < H_SE);
    stage0_s[1] = (v_q >= V_SS) && (v_q < V_SE);
    stage0_s[2] = (h_q < H_ACT) && (v_q < V_ACT);
`ifdef VGA_TEST_PATTERN_EN
    stage0_s[5:3] = 3'(h_q / BAR_W);
`endif
  end

  generate
    if (PIXEL_LATENCY == 0) begin : g_nodly
      assign tap_s = stage0_s;
    end else begin : g_dly
      logic [PW-1:0] dly_q [PIXEL_LATENCY];

      // Delay line matching the row buffer's read latency.
      always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIXEL_LATENCY; i++) dly_q[i] <= {PW{1'b0}};
        end else begin
          dly_q[0] <= stage0_s;
          for (int i = 1; i < PIXEL_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign tap_s = dly_q[PIXEL_LATENCY-1];
    end
  endgenerate

  // RGB565 field extraction; the byte-swapped form is the row buffer's native order.
  always_comb begin
    if (BYTE_SWAP != 0) begin
      r5_s = vga.pixel_data[7:3];
      g6_s = {vga.pixel_data[2:0], vga.pixel_data[15:13]};
      b5_s = vga.pixel_data[12:8];
    end else begin
      r5_s = vga.pixel_data[15:11];
      g6_s = vga.pixel_data[10:5];
      b5_s = vga.pixel_data[4:0];
    end
  end

  // Output-stage next values: sync polarity, de and blanked or pattern RGB.
  always_comb begin
    hsync_d = tap_s[0] ? ~HS_IDLE : HS_IDLE;
    vsync_d = tap_s[1] ? ~VS_IDLE : VS_IDLE;
    de_d    = tap_s[2];
    red_d   = {COLOR_BITS{1'b0}};
    green_d = {COLOR_BITS{1'b0}};
    blue_d  = {COLOR_BITS{1'b0}};
    if (tap_s[2]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (vga.test_en) begin
        red_d   = {COLOR_BITS{tap_s[5]}};
        green_d = {COLOR_BITS{tap_s[4]}};
        blue_d  = {COLOR_BITS{tap_s[3]}};
      end else begin
        red_d   = reduce_c({1'b0, r5_s}, 5);
        green_d = reduce_c(g6_s, 6);
        blue_d  = reduce_c({1'b0, b5_s}, 5);
      end
`else
      red_d   = reduce_c({1'b0, r5_s}, 5);
      green_d = reduce_c(g6_s, 6);
      blue_d  = reduce_c({1'b0, b5_s}, 5);
`endif
    end else begin
      red_d   = {COLOR_BITS{1'b0}};
      green_d = {COLOR_BITS{1'b0}};
      blue_d  = {COLOR_BITS{1'b0}};
    end
  end

  // State and output registers; reset parks v on the last line so h=0 starts a fresh frame.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= 10'd0;
      v_q           <= V_LAST;
      start_row_q   <= 1'b0;
      start_frame_q <= 1'b0;
      hsync_q       <= HS_IDLE;
      vsync_q       <= VS_IDLE;
      de_q          <= 1'b0;
      red_q         <= {COLOR_BITS{1'b0}};
      green_q       <= {COLOR_BITS{1'b0}};
      blue_q        <= {COLOR_BITS{1'b0}};
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      start_row_q   <= start_row_d;
      start_frame_q <= start_frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign vga.h_counter   = h_q;
  assign vga.v_counter   = v_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;
  assign vga.start_row   = start_row_q;
  assign vga.start_frame = start_frame_q;

endmodule
